// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter decoder.
package ring_pkg;

    localparam int unsigned RING_WIDTH_DEFAULT = 4;
    // Widest ring the rotate helper handles.
    localparam int unsigned RING_WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } ring_state_e;

    // Rotate the low `width` bits of v left by one; bit width-1 wraps to bit 0.
    // Bits at and above `width` come back as zero.
    function automatic logic [RING_WIDTH_MAX-1:0] ring_rotl(
        input logic [RING_WIDTH_MAX-1:0] v,
        input int unsigned               width
    );
        logic [RING_WIDTH_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < RING_WIDTH_MAX; i++) begin
            if (i < width) begin
                r[(i + 1 == width) ? 0 : i + 1] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_onehot_chk.sv
// Combinational one-hot check and binary position encoder for a ring pattern.
module ring_onehot_chk
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = RING_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0]         pattern,
    output logic                     is_onehot,
    output logic [$clog2(WIDTH)-1:0] pos
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    // OR of set-bit positions; only meaningful when exactly one bit is set.
    always_comb begin
        is_onehot = ($countones(pattern) == 1);
        pos       = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pattern[i]) begin
                pos = pos | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter decoder: reports the position of the set bit, tracks the
// rotate-left sequence with a SEARCH/ACQUIRE/LOCKED FSM and flags errors.
// Optional feature: define RING_DECODER_ERRCNT_EN to build the saturating
// error counter; otherwise err_count is tied to zero.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH     = RING_WIDTH_DEFAULT,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     in_valid,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     index_valid,
    output logic                     locked,
    output logic                     onehot_err,
    output logic                     seq_err,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

    ring_state_e state_q, state_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0] ref_q;
    logic [IDX_W-1:0] index_q;
    logic             index_valid_q, onehot_err_q, seq_err_q;

    logic             is_onehot;
    logic [IDX_W-1:0] pos;
    logic [RING_WIDTH_MAX-1:0] ref_ext, in_ext;
    logic             in_seq;
    logic             onehot_err_d, seq_err_d;

    ring_onehot_chk #(
        .WIDTH(WIDTH)
    ) u_onehot_chk (
        .pattern  (ring_in),
        .is_onehot(is_onehot),
        .pos      (pos)
    );

    // Sample is the expected successor of the reference (a repeat never is).
    always_comb begin
        ref_ext              = '0;
        ref_ext[WIDTH-1:0]   = ref_q;
        in_ext               = '0;
        in_ext[WIDTH-1:0]    = ring_in;
        in_seq               = (ring_rotl(ref_ext, WIDTH) == in_ext);
    end

    // FSM state and good-transition counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    // Next-state logic; idle cycles hold everything.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (in_valid) begin
            if (!is_onehot) begin
                state_d    = SEARCH;
                good_cnt_d = '0;
            end else begin
                unique case (state_q)
                    SEARCH: begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                    end
                    ACQUIRE: begin
                        if (in_seq) begin
                            if (good_cnt_q == CNT_W'(LOCK_CNT - 1)) begin
                                state_d    = LOCKED;
                                good_cnt_d = CNT_W'(LOCK_CNT);
                            end else begin
                                good_cnt_d = good_cnt_q + 1'b1;
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!in_seq) begin
                            state_d    = ACQUIRE;
                            good_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d    = SEARCH;
                        good_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    // Error pulses for this sample and the lock flag from the current state.
    always_comb begin
        onehot_err_d = in_valid && !is_onehot;
        seq_err_d    = in_valid && is_onehot && (state_q != SEARCH) && !in_seq;
        locked       = (state_q == LOCKED);
    end

    // Registered reference, index and per-sample pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q         <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            onehot_err_q  <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            index_valid_q <= in_valid && is_onehot;
            onehot_err_q  <= onehot_err_d;
            seq_err_q     <= seq_err_d;
            if (in_valid && is_onehot) begin
                ref_q   <= ring_in;
                index_q <= pos;
            end
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign onehot_err  = onehot_err_q;
    assign seq_err     = seq_err_q;

`ifdef RING_DECODER_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_count_q;

    // Saturating count of samples that raised either error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else if ((onehot_err_d || seq_err_d) && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Randomised self-checking bench for ring_decoder against a position-based
// reference model. Honours RING_DECODER_ERRCNT_EN for err_count expectations.
module tb_ring_decoder;

    localparam int unsigned W    = 4;
    localparam int unsigned LOCK = 3;
    localparam int unsigned IW   = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  ring_in;
    logic          in_valid;

    logic [IW-1:0] index,       index_s;
    logic          index_valid, index_valid_s;
    logic          locked,      locked_s;
    logic          onehot_err,  onehot_err_s;
    logic          seq_err,     seq_err_s;
    logic [7:0]    err_count;
    logic [1:0]    err_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=search 1=acquire 2=locked, positions as ints.
    int m_mode, m_ref, m_good, m_index, m_errs;
    bit m_iv, m_oe, m_se;

    ring_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ring_in(ring_in), .in_valid(in_valid),
        .index(index), .index_valid(index_valid), .locked(locked),
        .onehot_err(onehot_err), .seq_err(seq_err), .err_count(err_count)
    );

    ring_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ring_in(ring_in), .in_valid(in_valid),
        .index(index_s), .index_valid(index_valid_s), .locked(locked_s),
        .onehot_err(onehot_err_s), .seq_err(seq_err_s), .err_count(err_count_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_err(input int total, input int maxv);
        int r;
        r = (total > maxv) ? maxv : total;
`ifndef RING_DECODER_ERRCNT_EN
        r = 0;
`endif
        return r;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_ref = 0; m_good = 0; m_index = 0; m_errs = 0;
        m_iv = 0; m_oe = 0; m_se = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [W-1:0] pat);
        int p;
        m_oe = 0; m_se = 0; m_iv = 0;
        if (!v) return;
        if ($countones(pat) != 1) begin
            m_oe = 1; m_mode = 0; m_good = 0; m_errs++;
            return;
        end
        p = 0;
        for (int i = 0; i < W; i++) if (pat[i]) p = i;
        m_iv = 1; m_index = p;
        if (m_mode == 0) begin
            m_mode = 1; m_good = 0;
        end else if (p == (m_ref + 1) % W) begin
            if (m_mode == 1) begin
                m_good++;
                if (m_good == LOCK) m_mode = 2;
            end
        end else begin
            m_se = 1; m_good = 0; m_mode = 1; m_errs++;
        end
        m_ref = p;
    endfunction

    task automatic check_outputs();
        check_eq("index",         32'(index),         32'(m_index));
        check_eq("index_valid",   32'(index_valid),   32'(m_iv));
        check_eq("locked",        32'(locked),        32'(m_mode == 2));
        check_eq("onehot_err",    32'(onehot_err),    32'(m_oe));
        check_eq("seq_err",       32'(seq_err),       32'(m_se));
        check_eq("err_count",     32'(err_count),     32'(exp_err(m_errs, 255)));
        check_eq("sat_locked",    32'(locked_s),      32'(m_mode == 2));
        check_eq("sat_index",     32'(index_s),       32'(m_index));
        check_eq("sat_err_count", 32'(err_count_s),   32'(exp_err(m_errs, 3)));
    endtask

    // Present one input cycle, then check the registered response.
    task automatic step(input bit v, input logic [W-1:0] pat);
        in_valid = v;
        ring_in  = pat;
        @(posedge clk);
        model_step(v, pat);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] pat;
        int r;
        rst = 1'b1; in_valid = 1'b0; ring_in = '0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lock-up.
        step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100);
        check_eq("lockup_not_yet", 32'(locked), 32'd0);
        step(1, 4'b1000);
        check_eq("lockup_locked", 32'(locked), 32'd1);
        check_eq("lockup_index", 32'(index), 32'd3);

        // Wrap-around.
        step(1, 4'b0001);
        check_eq("wrap_seq_err", 32'(seq_err), 32'd0);
        check_eq("wrap_locked", 32'(locked), 32'd1);

        // Illegal patterns while locked.
        step(1, 4'b0010);
        step(1, 4'b0011);
        check_eq("illegal_pulse", 32'(onehot_err), 32'd1);
        check_eq("illegal_index_kept", 32'(index), 32'd1);
        step(1, 4'b0000);
        check_eq("zero_pulse", 32'(onehot_err), 32'd1);

        // Re-lock, then skip from 0010 to 1000.
        step(1, 4'b0100); step(1, 4'b1000); step(1, 4'b0001); step(1, 4'b0010);
        check_eq("relock", 32'(locked), 32'd1);
        step(1, 4'b1000);
        check_eq("skip_seq_err", 32'(seq_err), 32'd1);
        check_eq("skip_index", 32'(index), 32'd3);
        step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100);
        check_eq("skip_relock", 32'(locked), 32'd1);

        // Idle gaps inside a locked sequence; also a repeated reference.
        step(1, 4'b1000); step(0, 4'b0110); step(0, 4'b0000);
        step(1, 4'b0001); step(0, 4'b1111); step(1, 4'b0010);
        check_eq("gap_locked", 32'(locked), 32'd1);
        step(1, 4'b0010);
        check_eq("repeat_seq_err", 32'(seq_err), 32'd1);

        // Reset mid-lock; the next sample is handled from SEARCH.
        step(1, 4'b0100); step(1, 4'b1000); step(1, 4'b0001);
        pulse_reset();
        check_eq("rst_locked", 32'(locked), 32'd0);
        step(1, 4'b0100);
        check_eq("post_rst_seq_err", 32'(seq_err), 32'd0);

        // Saturation of the narrow counter.
        for (int i = 0; i < 5; i++) step(1, 4'b0000);
        check_eq("sat_after_5", 32'(err_count_s), 32'(exp_err(5, 3)));

        // Random traffic, biased towards in-sequence samples.
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 39);
            pat = '0;
            if (r == 0) begin
                pulse_reset();
            end else if (r < 24) begin
                pat[(m_ref + 1) % W] = 1'b1;
                step(1, pat);
            end else if (r < 28) begin
                step(0, W'($urandom));
            end else if (r < 32) begin
                pat[$urandom_range(0, W - 1)] = 1'b1;
                step(1, pat);
            end else if (r < 36) begin
                step(1, W'($urandom));
            end else begin
                pat[m_ref] = 1'b1;
                step(1, pat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
